// File: rtl/shift_sched_if.sv
// Bundle of the requester, shared-shifter and response signals of shift_sched.
// The slave modport is the scheduler's view; the master modport is the view of
// whatever drives requests, returns the shifter result and takes responses.
interface shift_sched_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_i;
    logic [2:0]       req0_mode;
    logic [4:0]       req0_count;

    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_i;
    logic [2:0]       req1_mode;
    logic [4:0]       req1_count;

    logic [31:0]      sh_i;
    logic [2:0]       sh_mode;
    logic [4:0]       sh_count;
    logic [31:0]      sh_o;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_o;
    logic             rsp_id;
    logic             rsp_err;

    logic             busy;
    logic [CNT_W-1:0] op_cnt;

    modport slave (
        input  req0_valid, req0_i, req0_mode, req0_count,
        output req0_ready,
        input  req1_valid, req1_i, req1_mode, req1_count,
        output req1_ready,
        output sh_i, sh_mode, sh_count,
        input  sh_o,
        output rsp_valid, rsp_o, rsp_id, rsp_err,
        input  rsp_ready,
        output busy, op_cnt
    );

    modport master (
        output req0_valid, req0_i, req0_mode, req0_count,
        input  req0_ready,
        output req1_valid, req1_i, req1_mode, req1_count,
        input  req1_ready,
        input  sh_i, sh_mode, sh_count,
        output sh_o,
        input  rsp_valid, rsp_o, rsp_id, rsp_err,
        output rsp_ready,
        input  busy, op_cnt
    );
endinterface

// File: rtl/shift_sched.sv
// Two-requester scheduler in front of one shared combinational barrel shifter.
// One operation at a time: IDLE accepts (round-robin on ties), SHIFT captures
// the shifter result, RESP holds the response until it is taken. Illegal modes
// skip the shifter and answer with an error flag and a zero result.
module shift_sched #(
    parameter int MODE_MAX = 5,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    shift_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [31:0] MODE_MAX_U = MODE_MAX;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [31:0]      op_i_q, op_i_d;
    logic [2:0]       op_mode_q, op_mode_d;
    logic [4:0]       op_count_q, op_count_d;
    logic             op_id_q, op_id_d;
    logic [31:0]      rsp_o_q, rsp_o_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

    logic             grant0, grant1;
    logic [31:0]      sel_i;
    logic [2:0]       sel_mode;
    logic [4:0]       sel_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Grant: only in IDLE; a single valid wins, a tie goes to the requester
    // that did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    // Operand mux feeding the operand registers from the granted requester.
    always_comb begin
        sel_i     = grant1 ? bus.req1_i     : bus.req0_i;
        sel_mode  = grant1 ? bus.req1_mode  : bus.req0_mode;
        sel_count = grant1 ? bus.req1_count : bus.req0_count;
    end

    // Next-state and register updates for the IDLE -> SHIFT/RESP -> IDLE cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_i_d       = op_i_q;
        op_mode_d    = op_mode_q;
        op_count_d   = op_count_q;
        op_id_d      = op_id_q;
        rsp_o_d      = rsp_o_q;
        rsp_err_d    = rsp_err_q;
        op_cnt_d     = op_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    op_i_d       = sel_i;
                    op_mode_d    = sel_mode;
                    op_count_d   = sel_count;
                    op_id_d      = grant1;
                    last_grant_d = grant1;
                    if ({29'd0, sel_mode} > MODE_MAX_U) begin
                        rsp_o_d   = 32'd0;
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        state_d   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                rsp_o_d   = bus.sh_o;
                rsp_err_d = 1'b0;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    op_cnt_d = sat_inc(op_cnt_q);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_i_q       <= 32'd0;
            op_mode_q    <= 3'd0;
            op_count_q   <= 5'd0;
            op_id_q      <= 1'b0;
            rsp_o_q      <= 32'd0;
            rsp_err_q    <= 1'b0;
            op_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_i_q       <= op_i_d;
            op_mode_q    <= op_mode_d;
            op_count_q   <= op_count_d;
            op_id_q      <= op_id_d;
            rsp_o_q      <= rsp_o_d;
            rsp_err_q    <= rsp_err_d;
            op_cnt_q     <= op_cnt_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.sh_i       = op_i_q;
    assign bus.sh_mode    = op_mode_q;
    assign bus.sh_count   = op_count_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_o      = rsp_o_q;
    assign bus.rsp_id     = op_id_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.op_cnt     = op_cnt_q;

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: models the shared barrel shifter, drives the
// requesters and checks grants, latency, results, backpressure and reset.
module tb_shift_sched;

    localparam int CNT_W = 3;

    logic clk;
    logic rst_n;

    int checks;
    int errors;
    int shift_bad;
    logic [CNT_W-1:0] exp_cnt;

    shift_sched_if #(.CNT_W(CNT_W)) sif ();

    shift_sched #(.MODE_MAX(5), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    // Reference shifter: 0 sll, 1 srl, 2 rol, 3 sra, 5 ror, otherwise pass.
    function automatic logic [31:0] shifter(input logic [31:0] x, input logic [2:0] m,
                                            input logic [4:0] c);
        logic [63:0] d;
        d = {x, x};
        case (m)
            3'd0: return x << c;
            3'd1: return x >> c;
            3'd2: begin
                d = d << c;
                return d[63:32];
            end
            3'd3: return $signed(x) >>> c;
            3'd5: begin
                d = d >> c;
                return d[31:0];
            end
            default: return x;
        endcase
    endfunction

    always_comb sif.sh_o = shifter(sif.sh_i, sif.sh_mode, sif.sh_count);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags any cycle where the shifter is being used with an illegal mode.
    always @(negedge clk) begin
        if (sif.busy && !sif.rsp_valid && (sif.sh_mode > 3'd5)) shift_bad++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic bump_cnt();
        if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sif.req0_valid = 1'b0;
        sif.req1_valid = 1'b0;
        sif.rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic run_op(input logic id, input logic [31:0] i, input logic [2:0] mode,
                          input logic [4:0] cnt, input logic [31:0] exp_o, input logic exp_err);
        if (id) begin
            sif.req1_valid = 1'b1; sif.req1_i = i; sif.req1_mode = mode; sif.req1_count = cnt;
        end else begin
            sif.req0_valid = 1'b1; sif.req0_i = i; sif.req0_mode = mode; sif.req0_count = cnt;
        end
        sif.rsp_ready = 1'b1;
        #1;
        checks++;
        if ({sif.req1_ready, sif.req0_ready} !== (id ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL op_grant: ready r1r0=%b expected %b", {sif.req1_ready, sif.req0_ready},
                     (id ? 2'b10 : 2'b01));
        end
        @(posedge clk); #1;
        sif.req0_valid = 1'b0;
        sif.req1_valid = 1'b0;
        if (!exp_err) begin
            checks++;
            if ({sif.busy, sif.rsp_valid, sif.sh_i, sif.sh_mode, sif.sh_count} !==
                {1'b1, 1'b0, i, mode, cnt}) begin
                errors++;
                $display("FAIL op_shift: busy=%b vld=%b sh_i=%h mode=%0d cnt=%0d expected 1 0 %h %0d %0d",
                         sif.busy, sif.rsp_valid, sif.sh_i, sif.sh_mode, sif.sh_count, i, mode, cnt);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({sif.rsp_valid, sif.rsp_id, sif.rsp_err, sif.rsp_o} !== {1'b1, id, exp_err, exp_o}) begin
            errors++;
            $display("FAIL op_resp: vld=%b id=%b err=%b o=%h expected 1 %b %b %h",
                     sif.rsp_valid, sif.rsp_id, sif.rsp_err, sif.rsp_o, id, exp_err, exp_o);
        end
        @(posedge clk); #1;
        bump_cnt();
        checks++;
        if ({sif.rsp_valid, sif.busy, sif.op_cnt} !== {2'b00, exp_cnt}) begin
            errors++;
            $display("FAIL op_done: vld=%b busy=%b op_cnt=%0d expected 0 0 %0d",
                     sif.rsp_valid, sif.busy, sif.op_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sif.req0_valid = 1'b0; sif.req0_i = '0; sif.req0_mode = '0; sif.req0_count = '0;
        sif.req1_valid = 1'b0; sif.req1_i = '0; sif.req1_mode = '0; sif.req1_count = '0;
        sif.rsp_ready  = 1'b0;
        exp_cnt = '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({sif.rsp_valid, sif.busy, sif.rsp_id, sif.rsp_err, sif.rsp_o, sif.sh_i, sif.sh_mode,
                 sif.sh_count, sif.op_cnt, sif.req0_ready, sif.req1_ready} !== '0) begin
                errors++;
                $display("FAIL reset_state: vld=%b busy=%b o=%h sh_i=%h sh_mode=%0d sh_cnt=%0d op_cnt=%0d expected all 0",
                         sif.rsp_valid, sif.busy, sif.rsp_o, sif.sh_i, sif.sh_mode, sif.sh_count, sif.op_cnt);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic g;
        logic [31:0] exp_o;
        apply_reset();
        sif.req0_valid = 1'b1; sif.req0_i = 32'h11;  sif.req0_mode = 3'd0; sif.req0_count = 5'd1;
        sif.req1_valid = 1'b1; sif.req1_i = 32'h100; sif.req1_mode = 3'd1; sif.req1_count = 5'd4;
        sif.rsp_ready  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            g = (k == 1);
            exp_o = g ? 32'h10 : 32'h22;
            #1;
            checks++;
            if ({sif.req1_ready, sif.req0_ready} !== (g ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_grant%0d: ready r1r0=%b expected %b", k,
                         {sif.req1_ready, sif.req0_ready}, (g ? 2'b10 : 2'b01));
            end
            @(posedge clk); #1;
            checks++;
            if ({sif.busy, sif.req1_ready, sif.req0_ready} !== 3'b100) begin
                errors++;
                $display("FAIL rr_shift%0d: busy/r1/r0=%b expected 100", k,
                         {sif.busy, sif.req1_ready, sif.req0_ready});
            end
            @(posedge clk); #1;
            checks++;
            if ({sif.rsp_valid, sif.rsp_id, sif.rsp_o, sif.req1_ready, sif.req0_ready} !==
                {1'b1, g, exp_o, 2'b00}) begin
                errors++;
                $display("FAIL rr_resp%0d: vld=%b id=%b o=%h r1r0=%b expected 1 %b %h 00", k,
                         sif.rsp_valid, sif.rsp_id, sif.rsp_o, {sif.req1_ready, sif.req0_ready}, g, exp_o);
            end
            @(posedge clk);
            bump_cnt();
        end
        #1;
        sif.req0_valid = 1'b0;
        sif.req1_valid = 1'b0;
        checks++;
        if (sif.op_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL rr_count: op_cnt=%0d expected %0d", sif.op_cnt, exp_cnt);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        run_op(1'b0, 32'h0000_0001, 3'd0, 5'd4, 32'h0000_0010, 1'b0);
    endtask

    task automatic test_req1_modes();
        run_op(1'b1, 32'h8000_0000, 3'd3, 5'd4, 32'hF800_0000, 1'b0);
        run_op(1'b1, 32'h0000_0001, 3'd5, 5'd1, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_count_zero();
        run_op(1'b0, 32'hA5A5_1234, 3'd1, 5'd0, 32'hA5A5_1234, 1'b0);
    endtask

    task automatic test_illegal_mode();
        run_op(1'b0, 32'h1234_5678, 3'd6, 5'd3, 32'h0, 1'b1);
        run_op(1'b1, 32'hFFFF_FFFF, 3'd7, 5'd0, 32'h0, 1'b1);
        checks++;
        if (shift_bad !== 0) begin
            errors++;
            $display("FAIL illegal_in_shift: cycles=%0d expected 0", shift_bad);
        end
    endtask

    task automatic test_backpressure();
        sif.req0_valid = 1'b1; sif.req0_i = 32'h0000_00F0; sif.req0_mode = 3'd1; sif.req0_count = 5'd4;
        sif.rsp_ready  = 1'b0;
        @(posedge clk); #1;
        sif.req0_valid = 1'b0;
        sif.req1_valid = 1'b1; sif.req1_i = 32'h1; sif.req1_mode = 3'd0; sif.req1_count = 5'd31;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({sif.rsp_valid, sif.busy, sif.req1_ready, sif.rsp_id, sif.rsp_err, sif.rsp_o} !==
                {5'b11000, 32'h0000_000F}) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b busy=%b r1=%b id=%b err=%b o=%h expected 1 1 0 0 0 0000000f",
                         k, sif.rsp_valid, sif.busy, sif.req1_ready, sif.rsp_id, sif.rsp_err, sif.rsp_o);
            end
            @(posedge clk); #1;
        end
        sif.rsp_ready = 1'b1;
        #1;
        checks++;
        if (sif.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_grant_on_take: req1_ready=%b expected 0", sif.req1_ready);
        end
        @(posedge clk); #1;
        bump_cnt();
        checks++;
        if ({sif.rsp_valid, sif.req1_ready, sif.op_cnt} !== {2'b01, exp_cnt}) begin
            errors++;
            $display("FAIL bp_idle: vld=%b r1=%b op_cnt=%0d expected 0 1 %0d",
                     sif.rsp_valid, sif.req1_ready, sif.op_cnt, exp_cnt);
        end
        @(posedge clk); #1;
        sif.req1_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({sif.rsp_valid, sif.rsp_id, sif.rsp_o} !== {2'b11, 32'h8000_0000}) begin
            errors++;
            $display("FAIL bp_second: vld=%b id=%b o=%h expected 1 1 80000000",
                     sif.rsp_valid, sif.rsp_id, sif.rsp_o);
        end
        @(posedge clk); #1;
        bump_cnt();
        checks++;
        if (sif.op_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL bp_count_sat: op_cnt=%0d expected %0d", sif.op_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        sif.req0_valid = 1'b1; sif.req0_i = 32'hDEAD_BEEF; sif.req0_mode = 3'd0; sif.req0_count = 5'd8;
        sif.rsp_ready  = 1'b1;
        @(posedge clk); #1;
        sif.req0_valid = 1'b0;
        checks++;
        if (sif.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_shift: busy=%b expected 1", sif.busy);
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({sif.rsp_valid, sif.busy, sif.rsp_id, sif.rsp_err, sif.rsp_o, sif.sh_i, sif.sh_mode,
                 sif.sh_count, sif.op_cnt} !== '0) begin
                errors++;
                $display("FAIL mid_reset%0d: vld=%b busy=%b o=%h sh_i=%h op_cnt=%0d expected all 0",
                         k, sif.rsp_valid, sif.busy, sif.rsp_o, sif.sh_i, sif.op_cnt);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        exp_cnt = '0;
        run_op(1'b1, 32'h0000_0F00, 3'd3, 5'd8, 32'h0000_000F, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        shift_bad = 0;
        test_reset();
        test_round_robin();
        test_basic();
        test_req1_modes();
        test_count_zero();
        test_illegal_mode();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
